// File: rtl/uart_tx_words.sv
// uart_tx_words: UART transmit serializer for the MVM result bus.
// Latency: tx shows the first start bit in the cycle after the s_valid && s_ready edge.
// Backpressure: s_ready is high only in IDLE; s_valid and s_data are ignored while a packet shifts out.
//
// Ports:
//   clk      system clock, rising edge
//   rstn     synchronous active-low reset
//   s_valid  s_data carries a packet
//   s_ready  block is idle and can take a packet (combinational)
//   s_data   W_BUS_Y-bit result bus; word iw = s_data[iw*BITS_PER_WORD +: BITS_PER_WORD]
//   tx       UART serial line, idles high, registered
//   busy     inverse of s_ready
module uart_tx_words #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int W_BUS_Y          = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W_BUS_Y-1:0] s_data,
  output logic               tx,
  output logic               busy
);

  localparam int N_WORDS = W_BUS_Y / BITS_PER_WORD;
  localparam int N_BITS  = N_WORDS * PACKET_SIZE_TX;
  // Counter widths never collapse to zero, so CLOCKS_PER_PULSE=1 still has a 1-bit counter.
  localparam int PCW     = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BCW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [PCW-1:0] PULSE_LAST = PCW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(N_BITS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [PCW-1:0]    pulse_cnt;
  logic [BCW-1:0]    bit_idx;
  // Holds the bits still to be sent after the one currently on tx.
  logic [N_BITS-1:0] shreg;
  logic [N_BITS-1:0] framed;

  // Whole packet framed up front: start 0, data LSB first, then ones as stop/padding.
  always_comb begin
    framed = '1;
    for (int iw = 0; iw < N_WORDS; iw++) begin
      framed[iw*PACKET_SIZE_TX] = 1'b0;
      framed[iw*PACKET_SIZE_TX+1 +: BITS_PER_WORD] = s_data[iw*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  assign s_ready = (state == IDLE);
  assign busy    = ~s_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      tx        <= 1'b1;
      pulse_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx        <= 1'b1;
          pulse_cnt <= '0;
          bit_idx   <= '0;
          if (s_valid) begin
            // The first bit goes straight to tx so the start bit appears right after the handshake.
            state <= SEND;
            tx    <= framed[0];
            shreg <= {1'b1, framed[N_BITS-1:1]};
          end
        end
        SEND: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state   <= IDLE;
              tx      <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + BCW'(1);
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[N_BITS-1:1]};
            end
          end else begin
            pulse_cnt <= pulse_cnt + PCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_words.sv
// Bench for uart_tx_words: two instances (CPP=4/13-bit frames and CPP=1/10-bit frames).
// Expected words are queued when a packet is driven and checked by a per-cycle tx decoder.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_words;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid, s_valid1;
  logic [15:0] s_data, s_data1;
  logic        s_ready, s_ready1;
  logic        tx, tx1;
  logic        busy, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_words dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx      (tx),
    .busy    (busy)
  );

  uart_tx_words #(
    .CLOCKS_PER_PULSE (1),
    .BITS_PER_WORD    (8),
    .PACKET_SIZE_TX   (10),
    .W_BUS_Y          (16)
  ) dut1 (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid1),
    .s_ready (s_ready1),
    .s_data  (s_data1),
    .tx      (tx1),
    .busy    (busy1)
  );

  // Decode one 2-word packet from the selected instance, starting at the first
  // falling edge after the handshake edge, then check the single idle cycle after it.
  task automatic recv(input bit sel);
    int   cpp;
    int   p;
    int   rdy_low;
    logic cur, first, mid;
    logic [7:0] word, expw;
    bit   frame_ok;
    cpp     = sel ? 1 : 4;
    p       = sel ? 10 : 13;
    rdy_low = 0;
    for (int w = 0; w < 2; w++) begin
      word     = '0;
      frame_ok = 1'b1;
      mid      = 1'b0;
      first    = 1'b0;
      for (int b = 0; b < p; b++) begin
        for (int c = 0; c < cpp; c++) begin
          @(negedge clk);
          cur = sel ? tx1 : tx;
          if ((sel ? s_ready1 : s_ready) === 1'b0) rdy_low++;
          if (c == 0) first = cur;
          else if (cur !== first) frame_ok = 1'b0;
          if (c == cpp / 2) mid = cur;
        end
        if (b == 0) begin
          if (mid !== 1'b0) frame_ok = 1'b0;
        end else if (b <= 8) begin
          word[b-1] = mid;
        end else begin
          if (mid !== 1'b1) frame_ok = 1'b0;
        end
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got %02h, required no word", word);
      end else begin
        expw = exp_q.pop_front();
        if (word !== expw) begin
          n_fail++;
          $display("FAIL word_data: got %02h, required %02h", word, expw);
        end
      end
      n_chk++;
      if (frame_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL word_framing: got frame_ok=%0b, required 1 (start 0, pad 1, bits held %0d cycles)", frame_ok, cpp);
      end
    end
    n_chk++;
    if (rdy_low !== 2 * p * cpp) begin
      n_fail++;
      $display("FAIL ready_low_cycles: got %0d, required %0d", rdy_low, 2 * p * cpp);
    end
    @(negedge clk);
    n_chk++;
    if ((sel ? tx1 : tx) !== 1'b1 || (sel ? s_ready1 : s_ready) !== 1'b1 || (sel ? busy1 : busy) !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_packet: got tx=%0b ready=%0b busy=%0b, required 1 1 0",
               sel ? tx1 : tx, sel ? s_ready1 : s_ready, sel ? busy1 : busy);
    end
  endtask

  // Present a packet on the default instance at the current falling edge.
  task automatic drive(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
  endtask

  task automatic test_reset;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_valid1 = 1'b0;
    s_data   = '0;
    s_data1  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got tx=%0b ready=%0b busy=%0b, required 1 1 0", tx, s_ready, busy);
    end
    n_chk++;
    if (tx1 !== 1'b1 || s_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_cpp1: got tx=%0b ready=%0b busy=%0b, required 1 1 0", tx1, s_ready1, busy1);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    drive(16'hA53C);
    fork
      recv(1'b0);
      begin @(negedge clk); s_valid = 1'b0; end
    join
  endtask

  task automatic test_back_to_back;
    drive(16'hFF80);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    fork
      recv(1'b0);
      begin @(negedge clk); s_data = 16'h0001; end
    join
    // s_valid is still high: the next edge accepts the second packet.
    fork
      recv(1'b0);
      begin @(negedge clk); s_valid = 1'b0; end
    join
  endtask

  task automatic test_ignore_during_send;
    drive(16'h1234);
    fork
      recv(1'b0);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          s_valid = k[0];
          s_data  = 16'hFFFF;
        end
        s_valid = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid_packet;
    s_valid = 1'b1;
    s_data  = 16'h0000;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (29) @(negedge clk);
    // Cycle 29: word0 data bit 6 of 0x00 is on the line.
    n_chk++;
    if (tx !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_packet_before_reset: got tx=%0b ready=%0b, required 0 0", tx, s_ready);
    end
    rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_packet: got tx=%0b ready=%0b busy=%0b, required 1 1 0", tx, s_ready, busy);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (tx !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_release: got tx=%0b ready=%0b, required 1 1", tx, s_ready);
    end
    drive(16'h00FF);
    fork
      recv(1'b0);
      begin @(negedge clk); s_valid = 1'b0; end
    join
  endtask

  task automatic test_cpp1;
    s_valid1 = 1'b1;
    s_data1  = 16'h5AA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    fork
      recv(1'b1);
      begin @(negedge clk); s_valid1 = 1'b0; end
    join
  endtask

  task automatic test_random;
    logic [15:0] d;
    int gap;
    for (int i = 0; i < 10; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      d = 16'($urandom);
      drive(d);
      fork
        recv(1'b0);
        begin @(negedge clk); s_valid = 1'b0; end
      join
    end
    n_chk++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_ignore_during_send;
    test_reset_mid_packet;
    test_cpp1;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_words.md
Name: uart_tx_words

Overview:
UART transmit serializer for the MVM result path. It accepts one parallel result bus (R outputs of W_Y_OUT bits, flattened) through a valid/ready handshake. It splits the bus into BITS_PER_WORD-bit words and sends them LSB-word-first on a single tx line. Each word is framed as start bit, data bits LSB-first, then stop/padding ones. It is the transmit counterpart of the system's UART receiver and drives uo_out[0] in tt_um_uart_mvm.

Parameters:
CLOCKS_PER_PULSE, 4, clock cycles per UART bit; must be >= 1.
BITS_PER_WORD, 8, data bits per UART word.
PACKET_SIZE_TX, 13, total bits per word frame (1 start + BITS_PER_WORD data + stop/padding ones); must be >= BITS_PER_WORD+2.
W_BUS_Y, 16, width of the parallel input bus (R*W_Y_OUT); must be a multiple of BITS_PER_WORD.
N_WORDS (derived), W_BUS_Y/BITS_PER_WORD, words per packet.

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
s_valid  input  1  s_data is valid.
s_ready  output  1  block can accept a packet.
s_data  input  W_BUS_Y  result bus; word iw = s_data[iw*BITS_PER_WORD +: BITS_PER_WORD].
tx  output  1  UART serial out; idles high.
busy  output  1  high while a packet is being shifted out (equals !s_ready).

Behaviour:
- Reset: rstn sampled low at a rising edge sets state IDLE, tx=1, and clears all counters and the shift register. The reset value of s_ready is 1 and busy is 0, but no handshake is accepted while rstn is low.
- s_ready is combinational: it is 1 only in IDLE.
- Handshake: s_valid && s_ready at a rising edge latches s_data. The state becomes SEND.
- Packet bit order: for iw = 0..N_WORDS-1, send 0 (start), then data bits 0..BITS_PER_WORD-1, then (PACKET_SIZE_TX-BITS_PER_WORD-1) ones.
- Words are sent back-to-back with no idle gap between frames.
- Implementation intent: preload an N_WORDS*PACKET_SIZE_TX-bit shift register with the framed packet, then shift LSB to tx.
- Bit timing: each packet bit drives tx for exactly CLOCKS_PER_PULSE cycles. tx is registered.
- Latency: tx goes 0 on the edge immediately after the handshake edge.
- Packet duration: the packet occupies exactly N_WORDS*PACKET_SIZE_TX*CLOCKS_PER_PULSE cycles of tx.
- Release: on the edge ending the last bit's final cycle, state returns to IDLE and tx=1. s_ready is high in the following cycle, so the minimum idle gap between packets is 1 cycle.
- Counters:
  - pulse counter 0..CLOCKS_PER_PULSE-1, wraps to 0 and advances the bit index;
  - bit index 0..N_WORDS*PACKET_SIZE_TX-1; the final wrap ends SEND.
- s_data and s_valid are ignored in SEND. Changes to s_data mid-packet have no effect on tx.
- s_valid held high continuously: a new packet is accepted on each IDLE cycle. Packets are never merged or dropped.
- Reset mid-packet: the packet is abandoned, tx=1 on the next edge, and there is no partial-frame completion.
- CLOCKS_PER_PULSE=1: bit changes every cycle; the counter logic must not underflow.
- No parity and no flow control on tx.

Test Plan:
1. W_BUS_Y=16, CPP=4, s_data=16'hA53C, single handshake.
   -> tx low 1 cycle after the handshake.
   -> Word0 bits: 0, 0,0,1,1,1,1,0,0, 1,1,1,1. Word1 bits: 0, 1,0,1,0,0,1,0,1, 1,1,1,1. Each bit held 4 cycles.
   -> s_ready low for exactly 104 cycles.
2. s_valid held high with 16'hFF80, then 16'h0001 presented on the next IDLE cycle.
   -> Two packets decode to 0x80,0xFF,0x01,0x00.
   -> Exactly 1 idle-high cycle between the packets.
3. Handshake 16'h1234, then s_data changed to 16'hFFFF and s_valid toggled during SEND.
   -> tx still decodes 0x34,0x12.
   -> No second packet until s_ready returns high.
4. rstn pulled low for one edge at cycle 30 of a packet.
   -> tx=1 from the next edge and s_ready=1 after reset release.
   -> A fresh 16'h00FF then transmits correctly from its own start bit.
5. CLOCKS_PER_PULSE=1, PACKET_SIZE_TX=10, s_data=16'h5AA5.
   -> 20-cycle packet: 0,10100101,1, then 0,01011010,1.
6. Randomized bus values, 10 packets, bench-side UART monitor sampling mid-bit.
   -> All words match, and every padding bit equals 1.
